burst_slave: RTL and testbench
==============================

BURST_SLAVE -- requirements
Module: burst_slave

Interface
REQ-001 Parameter ADDR_W, default 12, serial address length in bits.
REQ-002 Parameter DATA_W, default 8, data word length in bits.
REQ-003 Parameter MEM_AW, default 4, local memory address bits; depth 2**MEM_AW words.
REQ-004 Parameter SLAVE_ID, default 0, ADDR_W-MEM_AW bits, slave select value.
REQ-005 Parameter LEN_W, default 2, burst length field bits; burst = LEN+1 words.
REQ-006 Port clk  input  1  single clock; all logic on rising edge.
REQ-007 Port rstn  input  1  reset, asynchronous, active-low.
REQ-008 Port validIn  input  1  transaction frame from master; high for the whole transaction.
REQ-009 Port wren  input  1  1=write, 0=read; sampled on the start cycle only.
REQ-010 Port Address  input  1  serial address bits, then serial LEN bits, LSB first.
REQ-011 Port DataIn  input  1  serial write data, LSB first.
REQ-012 Port ready  output  1  high only in IDLE (slave can accept a new transaction).
REQ-013 Port validOut  output  1  qualifies DataOut during read data.
REQ-014 Port DataOut  output  1  serial read data, LSB first.

Function
REQ-015 States: IDLE, ADDR, LEN, WDATA, RDATA, WAIT_DROP; all outputs registered.
REQ-016 Start: IDLE and validIn rising (validIn=1, previous-cycle validIn=0) -> capture wren, go ADDR; validIn held high from a previous transaction does not restart.
REQ-017 ADDR: ADDR_W cycles starting the cycle after start, one Address bit per cycle, LSB first; then LEN for LEN_W cycles, same line, LSB first.
REQ-018 After the last LEN bit: if address[ADDR_W-1:MEM_AW] != SLAVE_ID -> WAIT_DROP, no memory access, validOut stays 0.
REQ-019 Selected write: WDATA for (LEN+1)*DATA_W cycles; word committed to mem[ptr] on the cycle its last bit is sampled; ptr then increments modulo 2**MEM_AW (wrap 15->0 at default).
REQ-020 Selected read: validOut=1 continuously for (LEN+1)*DATA_W cycles, starting the cycle after the last LEN bit; words from mem[ptr], ptr incrementing with wrap, no gap between words.
REQ-021 After the last write or read bit -> WAIT_DROP; WAIT_DROP -> IDLE on the cycle after validIn is sampled 0.
REQ-022 Abort: validIn=0 in ADDR, LEN, WDATA or RDATA -> IDLE next cycle; partial write word discarded; already committed words kept; validOut=0 from the next cycle.
REQ-023 DataIn and Address are ignored outside their own phases; wren changes after the start cycle have no effect.
REQ-024 Back-to-back: a new start is accepted once IDLE is reached and validIn rises again.

Reset
REQ-025 rstn low: state IDLE, ready=1, validOut=0, DataOut=0, counters and ptr 0, all memory words 0; takes effect immediately, including mid-transaction.
REQ-026 After rstn rises, the first start requires a validIn rising edge as in REQ-016.

Structure
REQ-027 A shared package holds the state enum and the default parameter constants (ADDR_W, DATA_W, MEM_AW, LEN_W).
REQ-028 One sub-module, burst_slave_mem: 2**MEM_AW x DATA_W register array with async reset, one write port and an asynchronous read port; the FSM and shift registers stay in burst_slave.

Verification
REQ-029 Write 0x004, LEN=0, data 0xA5 -> mem[4]=0xA5; ready=1 on the cycle after validIn drops.
REQ-030 Read 0x004, LEN=0 -> validOut high for exactly 8 cycles; DataOut = 1,0,1,0,0,1,0,1.
REQ-031 Burst write 0x00E, LEN=3, data 0x11,0x22,0x33,0x44 -> mem[14]=0x11, mem[15]=0x22, mem[0]=0x33, mem[1]=0x44; the matching burst read gives 32 contiguous validOut cycles with the same bytes.
REQ-032 Write 0x104 (ID mismatch), data 0xFF -> all memory unchanged, validOut never high, ready=0 until the cycle after validIn drops.
REQ-033 Write 0x005 with validIn dropped after 4 data bits -> mem[5] unchanged; ready=1 on the next cycle; a following write of 0x3C to 0x005 succeeds.
REQ-034 rstn pulsed low mid-read -> validOut=0 and ready=1 immediately; all memory reads 0 afterwards.

Source files
------------

// File: rtl/burst_slave_pkg.sv
// Shared definitions for the serial burst slave: FSM state encoding and
// default geometry constants.
package burst_slave_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_MEM_AW = 4;
  localparam int DEF_LEN_W  = 2;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LEN,
    WDATA,
    RDATA,
    WAIT_DROP
  } state_t;

endpackage

// File: rtl/burst_slave_mem.sv
// Local word store of the burst slave: resettable register array with one
// synchronous write port and a combinational read port.
module burst_slave_mem #(
  parameter int DATA_W = 8,
  parameter int MEM_AW = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              we,
  input  logic [MEM_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [MEM_AW-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** MEM_AW;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/burst_slave.sv
// Serial burst slave: receives address and burst length bit-serially, then
// streams write data into local memory or read data out of it, LSB first.
module burst_slave
  import burst_slave_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int MEM_AW = DEF_MEM_AW,
  parameter logic [ADDR_W-MEM_AW-1:0] SLAVE_ID = '0,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic clk,
  input  logic rstn,
  input  logic validIn,
  input  logic wren,
  input  logic Address,
  input  logic DataIn,
  output logic ready,
  output logic validOut,
  output logic DataOut
);

  localparam int CW = $clog2((ADDR_W > LEN_W ? ADDR_W : LEN_W) + 1);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t            state;
  logic              prev_valid;
  logic              is_write;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bcnt;
  logic [LEN_W-1:0]  wcnt;
  logic [LEN_W-1:0]  len;
  logic [ADDR_W-1:0] addr_sr;
  logic [LEN_W-1:0]  len_sr;
  logic [DATA_W-1:0] wr_sr;
  logic [MEM_AW-1:0] ptr;

  logic [ADDR_W-1:0] addr_next;
  logic [LEN_W-1:0]  len_full;
  logic [DATA_W-1:0] wr_word;
  logic              addr_hit;
  logic              last_bit;
  logic              last_word;
  logic              mem_we;
  logic [MEM_AW-1:0] raddr;
  logic [BW-1:0]     rbit;
  logic [DATA_W-1:0] rdata;

  assign addr_next = (addr_sr >> 1) | (ADDR_W'(Address) << (ADDR_W - 1));
  assign len_full  = (len_sr >> 1) | (LEN_W'(Address) << (LEN_W - 1));
  assign wr_word   = (wr_sr >> 1) | (DATA_W'(DataIn) << (DATA_W - 1));
  assign addr_hit  = (addr_sr[ADDR_W-1:MEM_AW] == SLAVE_ID);
  assign last_bit  = (bcnt == BW'(DATA_W - 1));
  assign last_word = (wcnt == len);
  assign mem_we    = (state == WDATA) && validIn && last_bit;

  // Select the bit that DataOut must present after the coming edge: the first
  // bit of the burst when leaving LEN, otherwise the next bit of the stream.
  always_comb begin
    raddr = ptr;
    rbit  = bcnt + BW'(1);
    if (state == LEN) begin
      raddr = addr_sr[MEM_AW-1:0];
      rbit  = '0;
    end else if (last_bit) begin
      raddr = ptr + MEM_AW'(1);
      rbit  = '0;
    end
  end

  burst_slave_mem #(
    .DATA_W(DATA_W),
    .MEM_AW(MEM_AW)
  ) u_mem (
    .clk  (clk),
    .rstn (rstn),
    .we   (mem_we),
    .waddr(ptr),
    .wdata(wr_word),
    .raddr(raddr),
    .rdata(rdata)
  );

  // prev_valid resets high so a validIn held across reset is not a start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      ready      <= 1'b1;
      validOut   <= 1'b0;
      DataOut    <= 1'b0;
      prev_valid <= 1'b1;
      is_write   <= 1'b0;
      cnt        <= '0;
      bcnt       <= '0;
      wcnt       <= '0;
      len        <= '0;
      addr_sr    <= '0;
      len_sr     <= '0;
      wr_sr      <= '0;
      ptr        <= '0;
    end else begin
      prev_valid <= validIn;
      case (state)
        IDLE: begin
          if (validIn && !prev_valid) begin
            is_write <= wren;
            cnt      <= '0;
            ready    <= 1'b0;
            state    <= ADDR;
          end
        end
        ADDR: begin
          if (!validIn) begin
            state <= IDLE;
            ready <= 1'b1;
          end else begin
            addr_sr <= addr_next;
            if (cnt == CW'(ADDR_W - 1)) begin
              cnt   <= '0;
              state <= LEN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        LEN: begin
          if (!validIn) begin
            state <= IDLE;
            ready <= 1'b1;
          end else begin
            len_sr <= len_full;
            if (cnt == CW'(LEN_W - 1)) begin
              len  <= len_full;
              ptr  <= addr_sr[MEM_AW-1:0];
              bcnt <= '0;
              wcnt <= '0;
              if (!addr_hit) begin
                state <= WAIT_DROP;
              end else if (is_write) begin
                state <= WDATA;
              end else begin
                state    <= RDATA;
                validOut <= 1'b1;
                DataOut  <= rdata[rbit];
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        WDATA: begin
          if (!validIn) begin
            state <= IDLE;
            ready <= 1'b1;
          end else begin
            wr_sr <= wr_word;
            if (last_bit) begin
              bcnt <= '0;
              wcnt <= wcnt + 1'b1;
              ptr  <= ptr + 1'b1;
              if (last_word) state <= WAIT_DROP;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
        end
        RDATA: begin
          if (!validIn) begin
            state    <= IDLE;
            ready    <= 1'b1;
            validOut <= 1'b0;
            DataOut  <= 1'b0;
          end else if (last_bit && last_word) begin
            state    <= WAIT_DROP;
            validOut <= 1'b0;
            DataOut  <= 1'b0;
          end else begin
            DataOut <= rdata[rbit];
            if (last_bit) begin
              bcnt <= '0;
              wcnt <= wcnt + 1'b1;
              ptr  <= ptr + 1'b1;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
        end
        WAIT_DROP: begin
          if (!validIn) begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          ready    <= 1'b1;
          validOut <= 1'b0;
          DataOut  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_burst_slave.sv
// Bench for burst_slave: directed scenarios plus random transactions checked
// against a byte-array model of the slave memory.
module tb_burst_slave;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam int MEM_AW = 4;
  localparam int LEN_W  = 2;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic validIn = 1'b0;
  logic wren = 1'b0;
  logic Address = 1'b0;
  logic DataIn = 1'b0;
  logic ready;
  logic validOut;
  logic DataOut;

  int compared = 0;
  int mismatched = 0;
  logic [7:0] model_mem [DEPTH];

  burst_slave #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MEM_AW  (MEM_AW),
    .SLAVE_ID(8'h00),
    .LEN_W   (LEN_W)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .validIn (validIn),
    .wren    (wren),
    .Address (Address),
    .DataIn  (DataIn),
    .ready   (ready),
    .validOut(validOut),
    .DataOut (DataOut)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One complete master transaction; drop >= 0 releases validIn after that
  // many data bits. The model decides what the slave must have done.
  task automatic applyStimulus(input bit wr, input logic [11:0] addr, input int len,
                               input logic [31:0] data, input int drop,
                               input string tag, output logic [31:0] read_data);
    int total;
    int nbits;
    bit aborted;
    bit selected;
    int ready_hi;
    int vo_hi;
    int idx;
    logic [1:0] len_bits;
    logic [31:0] obs;
    logic [31:0] expv;
    total    = (len + 1) * DATA_W;
    nbits    = (drop >= 0 && drop < total) ? drop : total;
    aborted  = (nbits < total);
    selected = (addr[11:4] == 8'h00);
    len_bits = len[1:0];
    ready_hi = 0;
    vo_hi    = 0;
    obs      = '0;
    expv     = '0;

    @(negedge clk);
    checkOutput({tag, ".ready_before"}, ready, 1);
    validIn = 1'b1;
    wren    = wr;
    for (int i = 0; i < ADDR_W + LEN_W; i++) begin
      @(negedge clk);
      if (ready) ready_hi++;
      if (validOut) vo_hi++;
      Address = (i < ADDR_W) ? addr[i] : len_bits[i-ADDR_W];
      wren    = 1'($urandom);
      DataIn  = 1'($urandom);
    end
    for (int j = 0; j < nbits; j++) begin
      @(negedge clk);
      if (ready) ready_hi++;
      if (validOut) begin
        vo_hi++;
        obs[j] = DataOut;
      end
      DataIn  = wr ? data[j] : 1'($urandom);
      Address = 1'($urandom);
    end
    @(negedge clk);
    if (ready) ready_hi++;
    checkOutput({tag, ".validOut_at_drop"}, validOut, (!wr && selected && aborted));
    validIn = 1'b0;
    @(negedge clk);
    checkOutput({tag, ".ready_after_drop"}, ready, 1);
    checkOutput({tag, ".validOut_after_drop"}, validOut, 0);
    checkOutput({tag, ".ready_low_during"}, ready_hi, 0);

    if (selected && !wr) begin
      for (int j = 0; j < nbits; j++) begin
        idx = (addr[3:0] + j / 8) % DEPTH;
        expv[j] = model_mem[idx][j%8];
      end
      checkOutput({tag, ".validOut_cycles"}, vo_hi, nbits);
      checkOutput({tag, ".read_data"}, obs, expv);
    end else begin
      checkOutput({tag, ".validOut_cycles"}, vo_hi, 0);
    end
    if (selected && wr) begin
      for (int w = 0; w < nbits / 8; w++) begin
        idx = (addr[3:0] + w) % DEPTH;
        model_mem[idx] = data[8*w +: 8];
      end
    end
    read_data = obs;
  endtask

  task automatic readAllMemory(input string tag);
    logic [31:0] rd;
    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(1'b0, 12'(a), 0, 32'h0, -1, $sformatf("%s.m%0d", tag, a), rd);
    end
  endtask

  initial begin
    logic [31:0] rd;
    bit wr;
    logic [11:0] addr;
    int len;
    int drop;

    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;

    #2 rstn = 1'b0;
    #1;
    checkOutput("reset.ready", ready, 1);
    checkOutput("reset.validOut", validOut, 0);
    checkOutput("reset.DataOut", DataOut, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    applyStimulus(1'b1, 12'h004, 0, 32'hA5, -1, "w004", rd);
    applyStimulus(1'b0, 12'h004, 0, 32'h0, -1, "r004", rd);
    checkOutput("r004.const", rd, 32'h000000A5);

    applyStimulus(1'b1, 12'h00E, 3, 32'h44332211, -1, "w00E", rd);
    applyStimulus(1'b0, 12'h00E, 3, 32'h0, -1, "r00E", rd);
    checkOutput("r00E.const", rd, 32'h44332211);
    applyStimulus(1'b0, 12'h000, 0, 32'h0, -1, "r000", rd);
    checkOutput("r000.const", rd, 32'h00000033);

    applyStimulus(1'b1, 12'h104, 0, 32'hFF, -1, "w104", rd);
    applyStimulus(1'b0, 12'h004, 0, 32'h0, -1, "r004b", rd);
    checkOutput("r004b.const", rd, 32'h000000A5);

    applyStimulus(1'b1, 12'h005, 0, 32'h77, 4, "w005abort", rd);
    applyStimulus(1'b0, 12'h005, 0, 32'h0, -1, "r005a", rd);
    checkOutput("r005a.const", rd, 32'h00000000);
    applyStimulus(1'b1, 12'h005, 0, 32'h3C, -1, "w005", rd);
    applyStimulus(1'b0, 12'h005, 0, 32'h0, -1, "r005b", rd);
    checkOutput("r005b.const", rd, 32'h0000003C);

    for (int t = 0; t < 40; t++) begin
      wr   = 1'($urandom_range(0, 1));
      len  = $urandom_range(0, 3);
      addr = {($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
              4'($urandom)};
      drop = ($urandom_range(0, 3) == 0) ? $urandom_range(0, (len + 1) * DATA_W - 1) : -1;
      applyStimulus(wr, addr, len, $urandom, drop, $sformatf("rnd%0d", t), rd);
    end
    readAllMemory("pre_reset");

    // Reset in the middle of a burst read, with validIn still held high.
    @(negedge clk);
    validIn = 1'b1;
    wren    = 1'b0;
    for (int i = 0; i < ADDR_W + LEN_W + 5; i++) begin
      @(negedge clk);
      Address = (i < 4) ? 1'b0 : ((i == 1 || i == 2 || i == ADDR_W || i == ADDR_W + 1) ? 1'b1 : 1'b0);
    end
    checkOutput("midread.validOut_before_reset", validOut, 1);
    #2 rstn = 1'b0;
    #1;
    checkOutput("midread.validOut_in_reset", validOut, 0);
    checkOutput("midread.ready_in_reset", ready, 1);
    checkOutput("midread.DataOut_in_reset", DataOut, 0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("held_valid.ready%0d", i), ready, 1);
      checkOutput($sformatf("held_valid.validOut%0d", i), validOut, 0);
    end
    validIn = 1'b0;
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
    readAllMemory("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
